voice_scheduler: RTL and testbench
==================================

# voice_scheduler

Sequences the shared single-port sample memory and the audio FIFO for the drum-pad playback path. Keeps one playback voice per pad and, once per output frame, fetches the current sample word of every voice through the one memory read port in round-robin order. It sums the fetched samples with saturation and writes one mixed sample to the codec FIFO when the FIFO has space. It sits between the drum-pad trigger logic, the sample memory and the audio codec FIFO.

## Interface
- NUM_VOICES, 4, number of voices/triggers; power of two, 2..8
- DATA_WIDTH, 16, sample width (signed two's complement), memory and FIFO data width
- ADDR_WIDTH, 16, memory address width
- SAMPLE_LEN, 16384, words per voice region; voice i occupies [i*SAMPLE_LEN, (i+1)*SAMPLE_LEN-1]; NUM_VOICES*SAMPLE_LEN ≤ 2**ADDR_WIDTH

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- triggers  in  NUM_VOICES  one-cycle start pulses, bit i starts voice i
- mem_addr  out  ADDR_WIDTH  read address to sample memory
- mem_data  in  DATA_WIDTH  read data; valid exactly 1 cycle after mem_addr
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_wr_en  out  1  write strobe, one word per high cycle
- fifo_data  out  DATA_WIDTH  mixed sample
- voice_active  out  NUM_VOICES  bit i high while voice i is playing
- busy  out  1  high in any state other than IDLE

## Operation
- Per-voice state: active bit, offset pointer ptr[i] (0..SAMPLE_LEN-1); address = i*SAMPLE_LEN + ptr[i].
- pending[i] is set by triggers[i] in any cycle and cleared when applied. pending is OR-ed with the current triggers when sampled.
- FSM states: IDLE, FETCH, DRAIN, WRITE.
- IDLE: if !fifo_full, start a frame. For every i with (pending|triggers)[i], set active[i]=1 and ptr[i]=0; this is a restart when the voice is already active. Clear pending and acc, set v=0, go to FETCH. If fifo_full, stay in IDLE and keep latching triggers.
- FETCH (NUM_VOICES cycles, v=0..N-1):
  - mem_addr = address of voice v.
  - For v>0, acc += active[v-1] ? sext(mem_data) : 0.
  - v increments each cycle; after v=N-1, go to DRAIN.
- DRAIN: acc += active[N-1] ? sext(mem_data) : 0. The saturated result is registered into fifo_data on exit. Go to WRITE.
- WRITE: fifo_wr_en = !fifo_full. When the write occurs:
  - For every active voice, ptr increments.
  - A voice whose ptr was SAMPLE_LEN-1 clears active and resets ptr to 0.
  - Go to IDLE.
  - If fifo_full, hold in WRITE with fifo_data stable.
- Arithmetic: acc is signed, DATA_WIDTH+log2(NUM_VOICES) bits, so it cannot overflow. The output clamps to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
- Triggers arriving while busy are applied at the next IDLE frame start, never mid-frame. Pointers for the in-flight frame are unaffected.
- All voices inactive: frames still run and write 0. This keeps the codec fed with silence.

## Timing
- Reset values:
  - Outputs: mem_addr=0, fifo_wr_en=0, fifo_data=0, voice_active=0, busy=0.
  - Internal: state=IDLE; pending, ptr and acc all cleared.
- Reset mid-frame aborts the frame with no FIFO write, and all voices stop.
- mem_addr is 0 outside FETCH.
- Frame length with FIFO space: NUM_VOICES+3 cycles (IDLE, N×FETCH, DRAIN, WRITE). This is 7 cycles for N=4.
- fifo_wr_en is high at most once per frame and never for two consecutive cycles.
- A trigger in a cycle where IDLE starts a frame is included in that frame.
- voice_active updates at the frame start (set) and at the WRITE edge (clear). A retrigger keeps the voice active without a gap.

## Test plan
- Reset with fifo_full=0 and no triggers → frames repeat every 7 cycles and write 0x0000. mem_addr steps 0, 16384, 32768, 49152 in FETCH.
- Memory word of 0x1000 in voice 1's region, triggers=4'b0010 → first frame writes 0x1000 and voice_active=4'b0010. After SAMPLE_LEN writes, voice_active=0 and the output is 0.
- Voices 0–3 each at 0x6000, all triggered → fifo_data=0x7FFF (saturate). Repeat with 0xA000 in each region → 0x8000.
- Hold fifo_full=1 through WRITE for 10 cycles → fifo_wr_en stays 0 and fifo_data stays stable. After release: exactly one write, then the next frame starts.
- Trigger voice 2 during FETCH of an active frame → it is applied at the next frame start. Retrigger of an active voice 2 at ptr=100 → the next fetch for voice 2 reads offset 0.
- Assert reset during FETCH with voices active → no write, all outputs return to reset values the next cycle, and voice_active=0.

Source files
------------

// File: rtl/voice_scheduler.sv
// Drum-pad playback scheduler: one voice per pad, round-robin sample fetch
// through a single memory read port, saturating mix, one FIFO word per frame.
module voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int SAMPLE_LEN = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] triggers,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  busy
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int PW = $clog2(SAMPLE_LEN);
  localparam int AW = DATA_WIDTH + VW;
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(SAMPLE_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

  state_t                  state;
  logic [VW-1:0]           v;
  logic [NUM_VOICES-1:0]   active;
  logic [NUM_VOICES-1:0]   pending;
  logic [PW-1:0]           ptr [NUM_VOICES];
  logic signed [AW-1:0]    acc;

  logic [NUM_VOICES-1:0]   start_mask;
  logic [VW-1:0]           v_next;
  logic [VW-1:0]           prev_v;
  logic                    add_en;
  logic signed [AW-1:0]    term;
  logic signed [AW-1:0]    acc_next;
  logic [DATA_WIDTH-1:0]   sat;

  function automatic logic [ADDR_WIDTH-1:0] voice_addr(input logic [VW-1:0] idx,
                                                        input logic [PW-1:0] p);
    return ADDR_WIDTH'(idx) * ADDR_WIDTH'(SAMPLE_LEN) + ADDR_WIDTH'(p);
  endfunction

  // Data returned this cycle belongs to the voice addressed last cycle; in
  // DRAIN v has wrapped to 0, so v-1 names the last voice.
  always_comb begin
    start_mask = pending | triggers;
    v_next     = v + VW'(1);
    prev_v     = v - VW'(1);
    add_en     = ((state == FETCH) && (v != '0)) || (state == DRAIN);
    term       = '0;
    if (add_en && active[prev_v])
      term = {{VW{mem_data[DATA_WIDTH-1]}}, mem_data};
    acc_next = acc + term;
    sat      = acc_next[DATA_WIDTH-1:0];
    if (!((&acc_next[AW-1:DATA_WIDTH-1]) || (~|acc_next[AW-1:DATA_WIDTH-1])))
      sat = acc_next[AW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  assign fifo_wr_en   = (state == WRITE) && !fifo_full;
  assign busy         = (state != IDLE);
  assign voice_active = active;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      v         <= '0;
      active    <= '0;
      pending   <= '0;
      acc       <= '0;
      mem_addr  <= '0;
      fifo_data <= '0;
      for (int i = 0; i < NUM_VOICES; i++) ptr[i] <= '0;
    end else begin
      pending <= pending | triggers;
      case (state)
        IDLE: begin
          if (!fifo_full) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (start_mask[i]) begin
                active[i] <= 1'b1;
                ptr[i]    <= '0;
              end
            end
            pending  <= '0;
            acc      <= '0;
            v        <= '0;
            // Voice 0 address must see a restart applied on this same edge.
            mem_addr <= voice_addr('0, start_mask[0] ? '0 : ptr[0]);
            state    <= FETCH;
          end
        end
        FETCH: begin
          acc <= acc_next;
          v   <= v_next;
          if (v == LAST_V) begin
            mem_addr <= '0;
            state    <= DRAIN;
          end else begin
            mem_addr <= voice_addr(v_next, ptr[v_next]);
          end
        end
        DRAIN: begin
          acc       <= acc_next;
          fifo_data <= sat;
          state     <= WRITE;
        end
        WRITE: begin
          if (!fifo_full) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (active[i]) begin
                if (ptr[i] == LAST_PTR) begin
                  active[i] <= 1'b0;
                  ptr[i]    <= '0;
                end else begin
                  ptr[i] <= ptr[i] + PW'(1);
                end
              end
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a registered sample-memory model;
// a short SAMPLE_LEN keeps end-of-sample behaviour within a short run.
module tb_voice_scheduler;

  localparam int NV = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int SL = 32;

  logic          clk;
  logic          reset;
  logic [NV-1:0] triggers;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data;
  logic [NV-1:0] voice_active;
  logic          busy;

  logic [DW-1:0] mem [0:65535];

  int checks;
  int failures;

  voice_scheduler #(
    .NUM_VOICES(NV), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_LEN(SL)
  ) dut (
    .clk(clk), .reset(reset), .triggers(triggers), .mem_addr(mem_addr),
    .mem_data(mem_data), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data), .voice_active(voice_active), .busy(busy)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill(input int r, input logic [DW-1:0] val);
    for (int j = 0; j < SL; j++) mem[r*SL + j] = val;
  endtask

  task automatic fill_ramp(input int r, input logic [DW-1:0] base);
    for (int j = 0; j < SL; j++) mem[r*SL + j] = DW'(base + DW'(j));
  endtask

  // Returns at the negedge of the cycle holding a FIFO write; n counts negedges waited.
  task automatic wait_wr(output logic [DW-1:0] d, output int n);
    d = '0;
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (fifo_wr_en) begin
        d = fifo_data;
        n = c;
        break;
      end
    end
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL wait_wr: no fifo write within 40 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; triggers = '0; fifo_full = 1'b0;
    repeat (3) step();
    checks += 5;
    if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
    if (fifo_data !== 16'h0000) begin failures++; $display("FAIL reset_fifo_data: got %h expected 0000", fifo_data); end
    if (voice_active !== 4'b0000) begin failures++; $display("FAIL reset_voice_active: got %b expected 0000", voice_active); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL first_frame_busy: got %b expected 1", busy); end
  endtask

  task automatic test_silence();
    logic [DW-1:0] d;
    int n;
    logic [AW-1:0] exp_addr [7];
    exp_addr[0] = 16'd0;          exp_addr[1] = 16'd0;
    exp_addr[2] = 16'(SL);        exp_addr[3] = 16'(2*SL);
    exp_addr[4] = 16'(3*SL);      exp_addr[5] = 16'd0;
    exp_addr[6] = 16'd0;
    wait_wr(d, n);
    checks += 2;
    if (d !== 16'h0000) begin failures++; $display("FAIL silence_data: got %h expected 0000", d); end
    if (n != 5) begin failures++; $display("FAIL silence_latency: got %0d expected 5", n); end
    for (int k = 0; k < 7; k++) begin
      step();
      checks += 3;
      if (mem_addr !== exp_addr[k]) begin failures++; $display("FAIL silence_addr[%0d]: got %h expected %h", k, mem_addr, exp_addr[k]); end
      if (fifo_wr_en !== (k == 6)) begin failures++; $display("FAIL silence_wr_en[%0d]: got %b expected %b", k, fifo_wr_en, (k == 6)); end
      if (busy !== (k != 0)) begin failures++; $display("FAIL silence_busy[%0d]: got %b expected %b", k, busy, (k != 0)); end
    end
    checks++;
    if (fifo_data !== 16'h0000) begin failures++; $display("FAIL silence_data2: got %h expected 0000", fifo_data); end
  endtask

  task automatic test_single_voice();
    logic [DW-1:0] d;
    int n;
    fill_ramp(1, 16'h1000);
    wait_wr(d, n);
    triggers = 4'b0010;
    step();
    triggers = '0;
    for (int k = 0; k < SL; k++) begin
      wait_wr(d, n);
      checks++;
      if (d !== 16'(16'h1000 + k)) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", k, d, 16'(16'h1000 + k)); end
      if (k == 0 || k == SL - 1) begin
        checks++;
        if (voice_active !== 4'b0010) begin failures++; $display("FAIL single_active[%0d]: got %b expected 0010", k, voice_active); end
      end
    end
    wait_wr(d, n);
    checks += 2;
    if (d !== 16'h0000) begin failures++; $display("FAIL single_end_data: got %h expected 0000", d); end
    if (voice_active !== 4'b0000) begin failures++; $display("FAIL single_end_active: got %b expected 0000", voice_active); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d;
    int n;
    logic [DW-1:0] vec [8][4];
    logic [DW-1:0] exp_d [8];
    vec[0] = '{16'h6000, 16'h6000, 16'h6000, 16'h6000}; exp_d[0] = 16'h7FFF;
    vec[1] = '{16'hA000, 16'hA000, 16'hA000, 16'hA000}; exp_d[1] = 16'h8000;
    vec[2] = '{16'h0100, 16'hFFFF, 16'h0010, 16'h7000}; exp_d[2] = 16'h710F;
    vec[3] = '{16'h4000, 16'h3FFF, 16'h0000, 16'h0000}; exp_d[3] = 16'h7FFF;
    vec[4] = '{16'hC000, 16'hC000, 16'h0000, 16'h0000}; exp_d[4] = 16'h8000;
    vec[5] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000}; exp_d[5] = 16'h8000;
    vec[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}; exp_d[6] = 16'h7FFF;
    vec[7] = '{16'h0001, 16'h8000, 16'h7FFF, 16'h0000}; exp_d[7] = 16'h0000;
    wait_wr(d, n);
    for (int r = 0; r < NV; r++) fill(r, vec[0][r]);
    triggers = 4'b1111;
    step();
    triggers = '0;
    for (int i = 0; i < 8; i++) begin
      wait_wr(d, n);
      checks++;
      if (d !== exp_d[i]) begin failures++; $display("FAIL mix_data[%0d]: got %h expected %h", i, d, exp_d[i]); end
      if (i == 0) begin
        checks++;
        if (voice_active !== 4'b1111) begin failures++; $display("FAIL mix_active: got %b expected 1111", voice_active); end
      end
      if (i < 7) for (int r = 0; r < NV; r++) fill(r, vec[i+1][r]);
    end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] d;
    int n;
    wait_wr(d, n);
    fill(0, 16'h0100); fill(1, 16'hFFFF); fill(2, 16'h0010); fill(3, 16'h7000);
    step();
    repeat (5) step();
    fifo_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks += 3;
      if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL hold_wr_en[%0d]: got %b expected 0", c, fifo_wr_en); end
      if (fifo_data !== 16'h710F) begin failures++; $display("FAIL hold_data[%0d]: got %h expected 710f", c, fifo_data); end
      if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy[%0d]: got %b expected 1", c, busy); end
    end
    fifo_full = 1'b0;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL release_wr_en: got %b expected 1", fifo_wr_en); end
    step();
    checks += 2;
    if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL release_single_write: got %b expected 0", fifo_wr_en); end
    if (busy !== 1'b0) begin failures++; $display("FAIL release_idle: got %b expected 0", busy); end
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks += 2;
      if (busy !== 1'b0) begin failures++; $display("FAIL idle_hold_busy[%0d]: got %b expected 0", c, busy); end
      if (mem_addr !== 16'h0000) begin failures++; $display("FAIL idle_hold_addr[%0d]: got %h expected 0000", c, mem_addr); end
    end
    fifo_full = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL idle_release_busy: got %b expected 1", busy); end
    wait_wr(d, n);
    checks += 2;
    if (d !== 16'h710F) begin failures++; $display("FAIL after_hold_data: got %h expected 710f", d); end
    if (n != 5) begin failures++; $display("FAIL after_hold_latency: got %0d expected 5", n); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    int n;
    wait_wr(d, n);
    repeat (3) step();
    checks++;
    if (voice_active !== 4'b1111) begin failures++; $display("FAIL pre_reset_active: got %b expected 1111", voice_active); end
    reset = 1'b1;
    step();
    checks += 5;
    if (mem_addr !== 16'h0000) begin failures++; $display("FAIL mid_reset_addr: got %h expected 0000", mem_addr); end
    if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_reset_wr_en: got %b expected 0", fifo_wr_en); end
    if (fifo_data !== 16'h0000) begin failures++; $display("FAIL mid_reset_data: got %h expected 0000", fifo_data); end
    if (voice_active !== 4'b0000) begin failures++; $display("FAIL mid_reset_active: got %b expected 0000", voice_active); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    step();
    checks++;
    if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_reset_wr_en2: got %b expected 0", fifo_wr_en); end
    reset = 1'b0;
    wait_wr(d, n);
    checks += 3;
    if (d !== 16'h0000) begin failures++; $display("FAIL post_reset_data: got %h expected 0000", d); end
    if (voice_active !== 4'b0000) begin failures++; $display("FAIL post_reset_active: got %b expected 0000", voice_active); end
    if (n != 6) begin failures++; $display("FAIL post_reset_latency: got %0d expected 6", n); end
  endtask

  task automatic test_retrigger();
    logic [DW-1:0] d;
    int n;
    fill(0, 16'h0200); fill(1, 16'h0030); fill_ramp(2, 16'h0001); fill(3, 16'h0000);
    triggers = 4'b0100;
    step();
    triggers = '0;
    for (int k = 0; k < 10; k++) begin
      wait_wr(d, n);
      checks++;
      if (d !== 16'(k + 1)) begin failures++; $display("FAIL ramp_data[%0d]: got %h expected %h", k, d, 16'(k + 1)); end
    end
    repeat (3) step();
    triggers = 4'b0101;
    step();
    triggers = '0;
    checks += 2;
    if (mem_addr !== 16'(2*SL + 10)) begin failures++; $display("FAIL inflight_addr: got %h expected %h", mem_addr, 16'(2*SL + 10)); end
    if (voice_active !== 4'b0100) begin failures++; $display("FAIL inflight_active: got %b expected 0100", voice_active); end
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if (voice_active[2] !== 1'b1) begin failures++; $display("FAIL retrig_gap[%0d]: got %b expected 1", c, voice_active[2]); end
      if (c == 3) begin
        checks += 3;
        if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL inflight_wr_en: got %b expected 1", fifo_wr_en); end
        if (fifo_data !== 16'h000B) begin failures++; $display("FAIL inflight_data: got %h expected 000b", fifo_data); end
        if (voice_active !== 4'b0100) begin failures++; $display("FAIL inflight_active2: got %b expected 0100", voice_active); end
      end
      if (c == 5) begin
        checks++;
        if (voice_active !== 4'b0101) begin failures++; $display("FAIL applied_active: got %b expected 0101", voice_active); end
      end
      if (c == 7) begin
        checks++;
        if (mem_addr !== 16'(2*SL)) begin failures++; $display("FAIL restart_addr: got %h expected %h", mem_addr, 16'(2*SL)); end
      end
      if (c == 10) begin
        checks += 2;
        if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL restart_wr_en: got %b expected 1", fifo_wr_en); end
        if (fifo_data !== 16'h0201) begin failures++; $display("FAIL restart_data: got %h expected 0201", fifo_data); end
      end
    end
  endtask

  task automatic test_idle_trigger();
    logic [DW-1:0] d;
    int n;
    step();
    triggers = 4'b0010;
    step();
    triggers = '0;
    checks++;
    if (voice_active !== 4'b0111) begin failures++; $display("FAIL idle_trig_active: got %b expected 0111", voice_active); end
    wait_wr(d, n);
    checks += 2;
    if (d !== 16'h0232) begin failures++; $display("FAIL idle_trig_data: got %h expected 0232", d); end
    if (n != 5) begin failures++; $display("FAIL idle_trig_latency: got %0d expected 5", n); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    triggers = '0;
    fifo_full = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    test_reset();
    test_silence();
    test_single_voice();
    test_saturation();
    test_fifo_full();
    test_mid_reset();
    test_retrigger();
    test_idle_trigger();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
